// File: rtl/vrf_operand_collector_if.sv
// ----------------------------------------------------------------------------
// vrf_operand_collector_if
// Bundles the three buses of the vector register file operand collector:
//   issue side   : in_valid, in_ready, in_tag, in_src_addr[NUM_SRC], in_src_use
//   regfile side : rd_addr[NUM_PORTS], rd_active, rd_data[NUM_PORTS]
//   execute side : out_valid, out_ready, out_tag, out_opnd[NUM_SRC], out_use
// Modports:
//   slave  - the collector itself
//   master - the environment (issue logic, register file, execute stage)
// ----------------------------------------------------------------------------
interface vrf_operand_collector_if #(
    parameter int NUM_REG   = 32,
    parameter int DATA_SIZE = 2048,
    parameter int NUM_SRC   = 3,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 8
);
    localparam int ADDRESS = $clog2(NUM_REG);

    // issue handshake
    logic                 in_valid;
    logic                 in_ready;
    logic [TAG_W-1:0]     in_tag;
    logic [ADDRESS-1:0]   in_src_addr [NUM_SRC];
    logic [NUM_SRC-1:0]   in_src_use;

    // register file read ports (combinational read)
    logic [ADDRESS-1:0]   rd_addr     [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_active;
    logic [DATA_SIZE-1:0] rd_data     [NUM_PORTS];

    // execute handshake
    logic                 out_valid;
    logic                 out_ready;
    logic [TAG_W-1:0]     out_tag;
    logic [DATA_SIZE-1:0] out_opnd    [NUM_SRC];
    logic [NUM_SRC-1:0]   out_use;

    modport slave (
        input  in_valid, in_tag, in_src_addr, in_src_use,
        output in_ready,
        output rd_addr, rd_active,
        input  rd_data,
        output out_valid, out_tag, out_opnd, out_use,
        input  out_ready
    );

    modport master (
        output in_valid, in_tag, in_src_addr, in_src_use,
        input  in_ready,
        input  rd_addr, rd_active,
        output rd_data,
        input  out_valid, out_tag, out_opnd, out_use,
        output out_ready
    );
endinterface

// File: rtl/vrf_operand_collector.sv
// ----------------------------------------------------------------------------
// vrf_operand_collector
// Read-side client of the vector register file. Accepts one instruction's
// source register addresses, reads the used sources through NUM_PORTS
// combinational register file read ports (lowest pending source index first),
// and holds the collected operands for the execute stage until it accepts.
// Ports:
//   clk   - clock
//   arst  - asynchronous reset, active-high
//   flush - synchronous abandon of the current instruction
//   bus   - vrf_operand_collector_if.slave (issue, regfile and execute buses)
// ----------------------------------------------------------------------------
module vrf_operand_collector #(
    parameter int NUM_REG   = 32,
    parameter int DATA_SIZE = 2048,
    parameter int NUM_SRC   = 3,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 8
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    flush,
    vrf_operand_collector_if.slave  bus
);
    localparam int ADDRESS = $clog2(NUM_REG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ADDRESS-1:0]   addr_q [NUM_SRC];
    logic [ADDRESS-1:0]   addr_d [NUM_SRC];
    logic [NUM_SRC-1:0]   use_q, use_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [DATA_SIZE-1:0] opnd_q [NUM_SRC];
    logic [DATA_SIZE-1:0] opnd_d [NUM_SRC];

    logic                 in_ready_c;
    logic                 accept;

    // rank[s] = number of pending sources below s; source s is served this
    // cycle on port rank[s] when it is pending and rank[s] < NUM_PORTS.
    int                   rank [NUM_SRC];

    // Acceptance is blocked while reset or flush is asserted.
    assign in_ready_c = !arst && !flush &&
                        ((state_q == IDLE) || ((state_q == READY) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        int cnt;
        cnt = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rank[s] = cnt;
            cnt     = cnt + int'(pend_q[s]);
        end
    end

    // Read port allocation: only COLLECT issues reads.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rd_addr[p]   = '0;
            bus.rd_active[p] = 1'b0;
        end
        if (state_q == COLLECT) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (pend_q[s] && (rank[s] == p)) begin
                        bus.rd_addr[p]   = addr_q[s];
                        bus.rd_active[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        use_d   = use_q;
        pend_d  = pend_q;
        opnd_d  = opnd_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            COLLECT: begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (pend_q[s] && (rank[s] == p)) begin
                            opnd_d[s] = bus.rd_data[p];
                            pend_d[s] = 1'b0;
                        end
                    end
                end
                if (pend_d == '0) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new instruction (from IDLE, or from READY in the handshake cycle)
        // starts with cleared slots so unused sources read back as zero.
        if (accept) begin
            tag_d  = bus.in_tag;
            addr_d = bus.in_src_addr;
            use_d  = bus.in_src_use;
            pend_d = bus.in_src_use;
            for (int s = 0; s < NUM_SRC; s++) begin
                opnd_d[s] = '0;
            end
            state_d = (bus.in_src_use != '0) ? COLLECT : READY;
        end

        if (flush) begin
            state_d = IDLE;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            use_q   <= '0;
            pend_q  <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                addr_q[s] <= '0;
                opnd_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            use_q   <= use_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            opnd_q  <= opnd_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == READY);
    assign bus.out_tag   = tag_q;
    assign bus.out_use   = use_q;
    assign bus.out_opnd  = opnd_q;

endmodule
